// File: rtl/imem_byte_loader.sv
// Byte-stream loader for the 256x8 instruction memory. It writes the stream
// sequentially from START_ADDR, pads a trailing partial word with PAD_BYTE,
// and flags an overflow when the stream runs past the top of memory.
module imem_byte_loader #(
  parameter int              ADDR_W     = 8,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter logic [7:0]      PAD_BYTE   = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   byte_count
);

  localparam int DEPTH = 2 ** ADDR_W;
  // Number of bytes that fit between START_ADDR and the top of memory.
  localparam logic [ADDR_W:0] CAP = (ADDR_W + 1)'(DEPTH) - {1'b0, START_ADDR};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PAD,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   bc_inc;
  logic              wr;
  logic              clr;
  logic [7:0]        wr_data;

  assign bc_inc = byte_count + (ADDR_W + 1)'(1);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Next-state logic plus the write/clear strobes for the datapath.
  always_comb begin
    state_n = state;
    wr      = 1'b0;
    clr     = 1'b0;
    wr_data = in_data;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_n = S_LOAD;
          clr     = 1'b1;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          wr = 1'b1;
          if (in_last) begin
            state_n = (bc_inc[1:0] == 2'b00) ? S_DONE : S_PAD;
          end else if (bc_inc == CAP) begin
            state_n = S_ERR;
          end
        end
      end
      S_PAD: begin
        wr      = 1'b1;
        wr_data = PAD_BYTE;
        if (bc_inc[1:0] == 2'b00) state_n = S_DONE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Registered memory write port, address pointer and byte counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_we     <= 1'b0;
      mem_addr   <= START_ADDR;
      mem_wdata  <= '0;
      ptr        <= START_ADDR;
      byte_count <= '0;
    end else begin
      mem_we <= wr;
      if (clr) begin
        ptr        <= START_ADDR;
        byte_count <= '0;
      end else if (wr) begin
        mem_addr   <= ptr;
        mem_wdata  <= wr_data;
        ptr        <= ptr + ADDR_W'(1);
        byte_count <= bc_inc;
      end
    end
  end

  // Status decode straight from the registered state.
  always_comb begin
    in_ready = (state == S_LOAD);
    busy     = (state == S_LOAD) || (state == S_PAD);
    done     = (state == S_DONE);
    error    = (state == S_ERR);
  end

endmodule
